// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci/Lucas sequence engine.
package fibo_pkg;

  // Control FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Output mode selected by the MODE input.
  localparam logic MODE_FINAL  = 1'b0;  // report only the final term
  localparam logic MODE_STREAM = 1'b1;  // stream every term over valid/ready

  // Sequence seeds: term(0) and term(1).
  localparam int FIB_S0 = 0;
  localparam int FIB_S1 = 1;
  localparam int LUC_S0 = 2;
  localparam int LUC_S1 = 1;

endpackage : fibo_pkg

// File: rtl/fibo_add_ovf.sv
// WIDTH-bit adder with carry-out; the carry marks a sum that does not fit.
module fibo_add_ovf #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Widen by one bit so the carry falls out of the same addition.
  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule : fibo_add_ovf

// File: rtl/fibo_seq_engine.sv
// Fibonacci/Lucas sequence engine: computes term N at WIDTH bits with
// overflow saturation, optionally streaming every term over valid/ready.
module fibo_seq_engine
  import fibo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NW    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [NW-1:0]    N,
  input  logic             MODE,
  input  logic             LUCAS,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             OVF,
  output logic             TERM_VALID,
  input  logic             TERM_READY,
  output logic [WIDTH-1:0] TERM_DATA,
  output logic [NW-1:0]    TERM_IDX
);

  localparam logic [WIDTH-1:0] FIB0 = WIDTH'(FIB_S0);
  localparam logic [WIDTH-1:0] FIB1 = WIDTH'(FIB_S1);
  localparam logic [WIDTH-1:0] LUC0 = WIDTH'(LUC_S0);
  localparam logic [WIDTH-1:0] LUC1 = WIDTH'(LUC_S1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;          // term(k)
  logic [WIDTH-1:0] b_q, b_d;          // term(k+1)
  logic [NW-1:0]    k_q, k_d;
  logic             b_ovf_q, b_ovf_d;  // term(k+1) did not fit
  logic [NW-1:0]    n_q, n_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             advance;

  fibo_add_ovf #(.WIDTH(WIDTH)) u_add (
    .a     (a_q),
    .b     (b_q),
    .sum   (sum),
    .carry (carry)
  );

  // In stream mode a step waits for the consumer; otherwise step every cycle.
  assign advance = (mode_q == MODE_FINAL) || TERM_READY;

  // Next-state, datapath and completion decisions.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    b_ovf_d  = b_ovf_q;
    n_d      = n_q;
    mode_d   = mode_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          n_d      = N;
          mode_d   = MODE;
          a_d      = LUCAS ? LUC0 : FIB0;
          b_d      = LUCAS ? LUC1 : FIB1;
          k_d      = '0;
          b_ovf_d  = 1'b0;
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (advance) begin
          // Target reached is tested before overflow so an exact final term
          // is reported even when its successor would not fit.
          if (k_q == n_q) begin
            result_d = a_q;
            ovf_d    = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else if (b_ovf_q) begin
            result_d = '1;
            ovf_d    = 1'b1;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            a_d     = b_q;
            b_d     = sum;
            b_ovf_d = carry;
            k_d     = k_q + NW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      b_ovf_q  <= 1'b0;
      n_q      <= '0;
      mode_q   <= MODE_FINAL;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      b_ovf_q  <= b_ovf_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign BUSY       = (state_q == ST_RUN);
  assign DONE       = done_q;
  assign RESULT     = result_q;
  assign OVF        = ovf_q;
  assign TERM_VALID = BUSY && (mode_q == MODE_STREAM);
  assign TERM_DATA  = a_q;
  assign TERM_IDX   = k_q;

endmodule : fibo_seq_engine

// File: doc/fibo_seq_engine.md
# fibo_seq_engine

Parametrised Fibonacci/Lucas sequence engine with an integrated datapath. It computes term N of the selected sequence at WIDTH bits and detects overflow. It can also stream every term F(0)..F(N) over a valid/ready handshake. It is the next-generation replacement for the fixed-width FSM-plus-decoder Fibonacci controller and sits directly under the top level, driven by the same START/DONE control.

## Interface
- WIDTH, 16: term width in bits, ≥2
- NW, 5: index width; N ranges 0..2^NW-1
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  request; sampled only in IDLE
- ABORT  in  1  cancel a running computation
- N  in  NW  target index; latched on accepted START
- MODE  in  1  0 = final result only, 1 = stream all terms; latched on START
- LUCAS  in  1  0 = Fibonacci seeds (0,1), 1 = Lucas seeds (2,1); latched on START
- BUSY  out  1  high while in RUN
- DONE  out  1  one-cycle completion pulse
- RESULT  out  WIDTH  last term; held until the next accepted START
- OVF  out  1  overflow flag; held with RESULT
- TERM_VALID  out  1  stream term present (MODE=1, RUN only)
- TERM_READY  in  1  consumer accepts the term
- TERM_DATA  out  WIDTH  current term A
- TERM_IDX  out  NW  current index k

## Operation
- Registers: A = term(k), B = term(k+1), k, and b_ovf (B not representable). Latched n, mode and lucas.
- States: IDLE, RUN.
- IDLE, START=1, ABORT=0: latch N/MODE/LUCAS; A←seed0, B←seed1, k←0, b_ovf←0; RESULT←0, OVF←0; go to RUN.
- RUN "advance condition": every cycle when mode=0; only when TERM_VALID & TERM_READY when mode=1.
- On the advance condition:
  - If k==n: RESULT←A, OVF←0, DONE pulse, go to IDLE.
  - Else if b_ovf=1: RESULT←all-ones, OVF←1, DONE pulse, go to IDLE.
  - Else: A←B, B←(A+B) mod 2^WIDTH, b_ovf←carry-out, k←k+1.
- k==n is compared before the increment, so k never wraps.
- TERM_VALID = RUN & mode. TERM_DATA = A, TERM_IDX = k (both combinational from registers). Data stays stable while TERM_READY is low.
- Overflow rule: every emitted term and any non-saturated RESULT is exact.
- ABORT in RUN: go to IDLE next edge with no DONE; RESULT/OVF unchanged. ABORT has priority over START and over the completion condition in the same cycle.
- START while in RUN is ignored.
- RST, including mid-run: state IDLE, BUSY 0, DONE 0, RESULT 0, OVF 0, A/B/k/b_ovf 0, so TERM_VALID 0, TERM_DATA 0, TERM_IDX 0.

## Timing
- Edge e0 accepts START; BUSY is high from after e0.
- Mode 0, no overflow: k advances once per edge e1..eN. At edge e(N+1), DONE=1, RESULT is valid and BUSY=0. Latency is N+1 cycles; N=0 gives latency 1.
- Mode 0, overflow at index m (term(m+1) does not fit, m<n): DONE/OVF at edge e(m+1).
- Mode 1: one term per cycle with TERM_READY held high; this matches mode 0 latency. Each low-READY cycle adds exactly one cycle.
- DONE is high for exactly one cycle; the next START can be accepted in the cycle DONE is high (state is already IDLE).

## Structure
- Package fibo_pkg holds:
  - state encoding constants (IDLE, RUN);
  - MODE_FINAL/MODE_STREAM constants;
  - seed constants FIB_S0=0, FIB_S1=1, LUC_S0=2, LUC_S1=1.
- Sub-module fibo_add_ovf: WIDTH-bit adder returning sum and carry-out. It is the only arithmetic in the block.
- The FSM, registers and handshake logic live in fibo_seq_engine.

## Test plan
- WIDTH=8: N=10, MODE=0, LUCAS=0 -> DONE 11 cycles after START edge, RESULT=55, OVF=0, BUSY high for 11 cycles.
- WIDTH=8, N=13 -> RESULT=233, OVF=0. N=20 -> DONE 14 cycles after START, RESULT=0xFF, OVF=1.
- MODE=1, N=5, TERM_READY toggled 1,0,1,0…:
  - TERM_DATA/TERM_IDX sequence 0/0,1/1,1/2,2/3,3/4,5/5;
  - data holds while READY=0;
  - RESULT=5, DONE once.
- LUCAS=1, N=0 -> RESULT=2 after 1 cycle; LUCAS=1, N=6 -> RESULT=18.
- ABORT at cycle 3 of N=20 run -> BUSY low next edge, no DONE, RESULT/OVF keep previous values; START in the same cycle as ABORT is ignored.
- RST asserted mid-run (N=20, cycle 5) -> all outputs 0 next edge. A new START with N=1 then gives RESULT=1, DONE after 2 cycles.
